// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM states and small op-decoding helpers.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MSUB  = 3'd6,
        OP_MSUBU = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_e;

    function automatic logic op_is_div(input logic [2:0] code);
        return (code == OP_DIV) || (code == OP_DIVU);
    endfunction

    // Every unsigned variant has an odd encoding.
    function automatic logic op_is_unsigned(input logic [2:0] code);
        return code[0];
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on unsigned magnitudes: one quotient bit per cycle,
// WIDTH cycles after start; valid rises once the last bit is formed.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] den;
    logic [CW-1:0]    steps;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // The dividend shifts out of the quotient register as quotient bits shift in.
    always_comb begin
        shifted = {remainder, quotient[WIDTH-1]};
        diff    = shifted - {1'b0, den};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quotient  <= '0;
            remainder <= '0;
            den       <= '0;
            steps     <= '0;
            valid     <= 1'b0;
        end else if (start) begin
            quotient  <= dividend;
            remainder <= '0;
            den       <= divisor;
            steps     <= CW'(WIDTH);
            valid     <= 1'b0;
        end else if (steps != '0) begin
            if (!diff[WIDTH]) begin
                remainder <= diff[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
                remainder <= shifted[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
            steps <= steps - 1'b1;
            if (steps == CW'(1))
                valid <= 1'b1;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers:
// fixed-latency multiply/accumulate and a bit-serial signed/unsigned divider.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CMAX = (MUL_LAT - 1 > WIDTH - 1) ? MUL_LAT - 1 : WIDTH - 1;
    localparam int CW   = $clog2(CMAX + 1);

    state_e           state, state_next;
    logic [CW-1:0]    cnt;
    op_e              op_q;
    logic [2*WIDTH-1:0] prod;
    logic             q_neg, r_neg, div_zero;

    logic             accept;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [2*WIDTH-1:0] rs_ext, rt_ext;
    logic [WIDTH-1:0] quo, rem, quo_s, rem_s;
    logic             div_valid;
    logic             commit_mul, commit_div, write_div;
    logic [2*WIDTH-1:0] mul_result;

    assign accept = start && !cancel && !hilo_we && (state == S_IDLE);

    always_comb begin
        rs_neg = !op_is_unsigned(op) && rs[WIDTH-1];
        rt_neg = !op_is_unsigned(op) && rt[WIDTH-1];
        rs_mag = rs_neg ? (~rs + 1'b1) : rs;
        rt_mag = rt_neg ? (~rt + 1'b1) : rt;
        rs_ext = {{WIDTH{rs_neg}}, rs};
        rt_ext = {{WIDTH{rt_neg}}, rt};
    end

    mdu_div_core #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (accept && op_is_div(op)),
        .dividend  (rs_mag),
        .divisor   (rt_mag),
        .quotient  (quo),
        .remainder (rem),
        .valid     (div_valid)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = op_is_div(op) ? S_DIV : S_MUL;
            S_MUL:  if (cnt == '0) state_next = S_IDLE;
            S_DIV:  if (cnt == '0) state_next = S_FIX;
            S_FIX:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        commit_mul = (state == S_MUL) && (cnt == '0);
        commit_div = (state == S_FIX);
        write_div  = commit_div && div_valid && !div_zero;
    end

    // Operands are consumed at issue: the product is formed here and only
    // combined with HI/LO at commit, so accumulates see the commit-time value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            op_q     <= OP_MULT;
            prod     <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            op_q     <= op_e'(op);
            prod     <= rs_ext * rt_ext;
            q_neg    <= rs_neg ^ rt_neg;
            r_neg    <= rs_neg;
            div_zero <= (rt == '0);
            cnt      <= op_is_div(op) ? CW'(WIDTH - 1) : CW'(MUL_LAT - 1);
        end else if ((state == S_MUL || state == S_DIV) && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        quo_s = q_neg ? (~quo + 1'b1) : quo;
        rem_s = r_neg ? (~rem + 1'b1) : rem;
        case (op_q)
            OP_MADD, OP_MADDU: mul_result = {hi, lo} + prod;
            OP_MSUB, OP_MSUBU: mul_result = {hi, lo} - prod;
            default:           mul_result = prod;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (hilo_we && !cancel) begin
            if (hilo_sel)
                lo <= rs;
            else
                hi <= rs;
        end else if (commit_mul) begin
            {hi, lo} <= mul_result;
        end else if (write_div) begin
            hi <= rem_s;
            lo <= quo_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            done <= 1'b0;
        else
            done <= commit_mul || commit_div;
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and randomized checks of mdu_iter against an arithmetic model of HI/LO.
module tb_mdu_iter;
    localparam int W = 32;
    localparam int L = 5;

    logic         clk = 1'b0;
    logic         reset, start, hilo_we, hilo_sel, cancel;
    logic [2:0]   op;
    logic [W-1:0] rs, rt, hi, lo;
    logic         busy, done;

    int           total = 0;
    int           bad = 0;
    logic [W-1:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W), .MUL_LAT(L)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .hilo_we  (hilo_we),
        .hilo_sel (hilo_sel),
        .cancel   (cancel),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference semantics straight from the instruction definitions.
    task automatic model_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb;
        logic [63:0] p, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        acc = {m_hi, m_lo};
        p   = '0;
        if (o == 3'd2) begin
            if (b != 0) begin
                m_lo = W'(sa / sb);
                m_hi = W'(sa % sb);
            end
        end else if (o == 3'd3) begin
            if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
        end else begin
            if (o[0]) p = {32'b0, a} * {32'b0, b};
            else      p = 64'(sa * sb);
            if (o == 3'd4 || o == 3'd5)      acc = acc + p;
            else if (o == 3'd6 || o == 3'd7) acc = acc - p;
            else                             acc = p;
            {m_hi, m_lo} = acc;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit intf);
        int lat, nbusy, exp_lat;
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); rs = $urandom; rt = $urandom;
        lat = 0; nbusy = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) nbusy++;
            start  = intf && (lat == 2);
            cancel = 1'($urandom);
            lat++;
            @(negedge clk);
        end
        start = 1'b0; cancel = 1'b0;
        model_op(o, a, b);
        exp_lat = (o == 3'd2 || o == 3'd3) ? W + 1 : L;
        check($sformatf("lat_op%0d", o), 64'(lat), 64'(exp_lat));
        check($sformatf("busy_cycles_op%0d", o), 64'(nbusy), 64'(exp_lat));
        check("busy_at_done", 64'(busy), 64'd0);
        check($sformatf("hi_op%0d_%h_%h", o, a, b), 64'(hi), 64'(m_hi));
        check($sformatf("lo_op%0d_%h_%h", o, a, b), 64'(lo), 64'(m_lo));
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic wr(input logic sel, input logic [W-1:0] val, input logic canc);
        @(negedge clk);
        hilo_we = 1'b1; hilo_sel = sel; rs = val; cancel = canc;
        @(negedge clk);
        hilo_we = 1'b0; cancel = 1'b0;
        if (!canc) begin
            if (sel) m_lo = val;
            else     m_hi = val;
        end
        check("wr_hi", 64'(hi), 64'(m_hi));
        check("wr_lo", 64'(lo), 64'(m_lo));
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            @(negedge clk);
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;
        reset = 1'b1; start = 1'b0; hilo_we = 1'b0; hilo_sel = 1'b0; cancel = 1'b0;
        op = '0; rs = '0; rt = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        run_op(3'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
        check("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
        check("mult_neg_lo", 64'(lo), 64'hFFFFFFEB);

        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_neg_lo", 64'(lo), 64'hFFFFFFFD);
        check("div_neg_hi", 64'(hi), 64'hFFFFFFFF);
        run_op(3'd3, 32'd7, 32'd2, 1'b0);
        check("divu_lo", 64'(lo), 64'd3);
        check("divu_hi", 64'(hi), 64'd1);

        wr(1'b0, 32'd0, 1'b0);
        wr(1'b1, 32'hFFFFFFFF, 1'b0);
        run_op(3'd5, 32'd1, 32'd1, 1'b0);
        check("maddu_carry", 64'({hi, lo}), 64'h0000000100000000);
        run_op(3'd7, 32'd1, 32'd1, 1'b0);
        check("msubu_borrow", 64'({hi, lo}), 64'h00000000FFFFFFFF);

        wr(1'b0, 32'hAA, 1'b0);
        wr(1'b1, 32'hBB, 1'b0);
        run_op(3'd2, 32'd5, 32'd0, 1'b0);
        check("div0_hi", 64'(hi), 64'hAA);
        check("div0_lo", 64'(lo), 64'hBB);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("div_ovf_lo", 64'(lo), 64'h80000000);
        check("div_ovf_hi", 64'(hi), 64'd0);

        // start blocked by cancel, then by a simultaneous HI/LO write
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 3'd0; rs = 32'd5; rt = 32'd5;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        watch_no_done("cancel_start", 12);
        check("cancel_hi", 64'(hi), 64'(m_hi));
        check("cancel_lo", 64'(lo), 64'(m_lo));
        wr(1'b0, 32'h1234, 1'b1);
        @(negedge clk);
        start = 1'b1; hilo_we = 1'b1; hilo_sel = 1'b1; op = 3'd0; rs = 32'd77; rt = 32'd3;
        @(negedge clk);
        start = 1'b0; hilo_we = 1'b0;
        m_lo = 32'd77;
        check("we_over_start_lo", 64'(lo), 64'd77);
        watch_no_done("we_over_start_idle", 10);
        run_op(3'd0, 32'd100, 32'd200, 1'b1);

        // reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 3'd2; rs = 32'd1000; rt = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        watch_no_done("midrst_no_commit", 40);
        run_op(3'd0, 32'd12345, 32'hFFFF0000, 1'b0);

        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            ro = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) rb = '0;
            if ($urandom_range(0, 15) == 0) begin
                ra = 32'h80000000; rb = 32'hFFFFFFFF;
            end
            if ($urandom_range(0, 5) == 0) rb = 32'($urandom_range(1, 9));
            if ($urandom_range(0, 9) == 0)
                wr(1'($urandom), ra, 1'($urandom));
            else
                run_op(ro, ra, rb, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and HI/LO width; legal values even, >= 8.
REQ-002 The block SHALL have parameter MUL_LAT, default 5, multiply-class latency in cycles, >= 1.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  issue operation
- op  in  3  operation code
- rs  in  WIDTH  operand A
- rt  in  WIDTH  operand B
- hilo_we  in  1  direct HI/LO write
- hilo_sel  in  1  0 = HI, 1 = LO
- cancel  in  1  pipeline exception, blocks issue this cycle
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  operation in flight
- done  out  1  one-cycle result-commit pulse

Function
REQ-004 op encodings SHALL be: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
REQ-005 hilo_we && !cancel SHALL write rs into HI (hilo_sel=0) or LO (hilo_sel=1) at the clock edge; priority over start.
REQ-006 A start with cancel high, with hilo_we high, or while busy SHALL be ignored.
REQ-007 An accepted start SHALL latch op, rs and rt; later input changes SHALL NOT affect the result.
REQ-008 FSM states SHALL be IDLE, MUL, DIV, FIX; reset state IDLE.
REQ-009 IDLE->MUL on accepted ops 0,1,4-7; IDLE->DIV on ops 2,3.
REQ-010 MUL SHALL count MUL_LAT-1 down to 0; at 0, commit {hi,lo} and return to IDLE.
REQ-011 MULT/MULTU SHALL produce the 2*WIDTH signed/unsigned product.
REQ-012 MADD/MADDU SHALL add the product to {hi,lo}, modulo 2^(2*WIDTH).
REQ-013 MSUB/MSUBU SHALL subtract the product from {hi,lo}, modulo 2^(2*WIDTH).
REQ-014 The {hi,lo} value used by accumulate ops SHALL be the value at commit time.
REQ-015 DIV SHALL run restoring division on operand magnitudes, one quotient bit per cycle, for WIDTH cycles; then FIX for 1 cycle.
REQ-016 FIX SHALL apply signs (quotient negated if signs differ, remainder takes the sign of rs), commit lo=quotient and hi=remainder, then go to IDLE.
REQ-017 Divide latency SHALL be WIDTH+1 cycles from start to commit.
REQ-018 Divide by zero SHALL leave hi and lo unchanged; done SHALL still pulse at normal latency.
REQ-019 Signed DIV of most-negative by -1 SHALL give lo=most-negative, hi=0.
REQ-020 busy SHALL be high exactly when state != IDLE: from the cycle after the accepted start through the commit cycle.
REQ-021 done SHALL be high for exactly the one cycle after the commit edge, coinciding with busy low and new hi/lo.
REQ-022 cancel SHALL NOT abort an operation already in flight.

Reset
REQ-023 Reset SHALL force state IDLE, counters 0, hi=0, lo=0, busy=0, done=0.
REQ-024 Reset mid-operation SHALL abort the operation with no commit.

Structure
REQ-025 Package mdu_pkg SHALL hold the op encoding constants and the FSM state enum.
REQ-026 The iterative divider datapath SHALL be sub-module mdu_div_core (start, dividend, divisor, quotient, remainder, valid), instantiated once.
REQ-027 The multiply product SHALL be computed at issue into a registered 2*WIDTH value and held for MUL_LAT cycles; no other sub-modules.

Verification
REQ-028 MULT rs=-3, rt=7 -> after 5 cycles hi=FFFFFFFF, lo=FFFFFFEB, done pulse, busy high 5 cycles.
REQ-029 DIV rs=-7, rt=2 -> after 33 cycles lo=FFFFFFFD, hi=FFFFFFFF; DIVU rs=7, rt=2 -> lo=3, hi=1.
REQ-030 hi=0, lo=FFFFFFFF, then MADDU rs=1, rt=1 -> hi=1, lo=0; then MSUBU rs=1, rt=1 -> hi=0, lo=FFFFFFFF.
REQ-031 DIV rs=5, rt=0 with hi=AA, lo=BB -> hi=AA, lo=BB after 33 cycles, done pulses; DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-032 start with cancel=1 -> busy stays 0, no commit; hilo_we with cancel=1 -> no write; start while busy -> ignored, first result intact.
REQ-033 Reset asserted at cycle 10 of a DIV -> hi=lo=0, busy=0, no done pulse; a new MULT issued afterwards completes normally.
